// File: rtl/vector_floating_point_multiply_add_sequencer.sv
// Read/execute/write sequencer around the combinational vector FP multiply-add unit.
// Optional per-element mask port enabled by VFMA_SEQUENCER_MASK_EN.
module vector_floating_point_multiply_add_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_LENGTH = 32,
  parameter int LEN_WIDTH  = $clog2(MAX_LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  vector_length,
  input  logic                  widening,
  input  logic [ADDR_WIDTH-1:0] src2_base,
  input  logic [ADDR_WIDTH-1:0] src1_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
`ifdef VFMA_SEQUENCER_MASK_EN
  input  logic [MAX_LENGTH-1:0] mask,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr_vs2,
  output logic [ADDR_WIDTH-1:0] rd_addr_vs1,
  output logic [ADDR_WIDTH-1:0] rd_addr_vd,
  input  logic [63:0]           rd_data_vs2,
  input  logic [63:0]           rd_data_vs1,
  input  logic [63:0]           rd_data_vd,
  output logic [63:0]           fma_vs2,
  output logic [63:0]           fma_vs1,
  output logic [63:0]           fma_vdd,
  input  logic [63:0]           fma_vd,
  input  logic [63:0]           fma_vd_high,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [63:0]           wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_EXECUTE,
    S_WRITE_LOW, S_WRITE_HIGH, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  index_q, index_d;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  wide_q;
  logic [ADDR_WIDTH-1:0] src2_q, src1_q, dst_q;
  logic [63:0]           result_low, result_high;
  logic                  advance;
  logic                  last;
  logic                  elem_active;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] idx_a, dst_lo, dst_hi;

  assign accept = start && (state_q == S_IDLE);
  assign last   = (index_q == len_q - LEN_WIDTH'(1));
  assign idx_a  = ADDR_WIDTH'(index_q);
  assign dst_lo = dst_q + (wide_q ? (idx_a << 1) : idx_a);
  assign dst_hi = dst_q + (idx_a << 1) + ADDR_WIDTH'(1);

`ifdef VFMA_SEQUENCER_MASK_EN
  logic [MAX_LENGTH-1:0] mask_q;
  logic [MAX_LENGTH-1:0] mask_sh;
  assign mask_sh     = mask_q >> index_q;
  assign elem_active = mask_sh[0];
`else
  assign elem_active = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      len_q       <= '0;
      wide_q      <= 1'b0;
      src2_q      <= '0;
      src1_q      <= '0;
      dst_q       <= '0;
      fma_vs2     <= '0;
      fma_vs1     <= '0;
      fma_vdd     <= '0;
      result_low  <= '0;
      result_high <= '0;
`ifdef VFMA_SEQUENCER_MASK_EN
      mask_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      if (accept) begin
        // Oversized requests are clamped to the register-file capacity
        len_q  <= (vector_length > LEN_WIDTH'(MAX_LENGTH)) ?
                  LEN_WIDTH'(MAX_LENGTH) : vector_length;
        wide_q <= widening;
        src2_q <= src2_base;
        src1_q <= src1_base;
        dst_q  <= dst_base;
`ifdef VFMA_SEQUENCER_MASK_EN
        mask_q <= mask;
`endif
      end
      if (state_q == S_CAPTURE) begin
        fma_vs2 <= rd_data_vs2;
        fma_vs1 <= rd_data_vs1;
        fma_vdd <= rd_data_vd;
      end
      if (state_q == S_EXECUTE) begin
        result_low  <= fma_vd;
        result_high <= fma_vd_high;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    advance     = 1'b0;
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    rd_en       = 1'b0;
    rd_addr_vs2 = '0;
    rd_addr_vs1 = '0;
    rd_addr_vd  = '0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          index_d = '0;
          state_d = (vector_length == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (elem_active) begin
          rd_en       = 1'b1;
          rd_addr_vs2 = src2_q + idx_a;
          rd_addr_vs1 = src1_q + idx_a;
          rd_addr_vd  = dst_lo;
          state_d     = S_CAPTURE;
        end else begin
          advance = 1'b1;
        end
      end
      S_CAPTURE: state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_WRITE_LOW;
      S_WRITE_LOW: begin
        wr_valid = 1'b1;
        wr_addr  = dst_lo;
        wr_data  = result_low;
        if (wr_ready) begin
          if (wide_q) state_d = S_WRITE_HIGH;
          else        advance = 1'b1;
        end
      end
      S_WRITE_HIGH: begin
        wr_valid = 1'b1;
        wr_addr  = dst_hi;
        wr_data  = result_high;
        if (wr_ready) advance = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (last) begin
        state_d = S_DONE;
      end else begin
        index_d = index_q + LEN_WIDTH'(1);
        state_d = S_READ;
      end
    end
  end

endmodule

// File: tb/tb_vector_floating_point_multiply_add_sequencer.sv
// Directed bench for the FMA sequencer: register-file and FMA models,
// table of commands plus stall, reset and mask sequences.
module tb_vector_floating_point_multiply_add_sequencer;

  localparam int AW = 5;
  localparam int ML = 32;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] vector_length = '0;
  logic          widening = 1'b0;
  logic [AW-1:0] src2_base = '0;
  logic [AW-1:0] src1_base = '0;
  logic [AW-1:0] dst_base = '0;
`ifdef VFMA_SEQUENCER_MASK_EN
  logic [ML-1:0] mask = '1;
`endif
  logic          busy, done, rd_en;
  logic [AW-1:0] rd_addr_vs2, rd_addr_vs1, rd_addr_vd;
  logic [63:0]   rd_data_vs2, rd_data_vs1, rd_data_vd;
  logic [63:0]   fma_vs2, fma_vs1, fma_vdd;
  logic [63:0]   fma_vd, fma_vd_high;
  logic          wr_valid;
  logic          wr_ready = 1'b1;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;

  vector_floating_point_multiply_add_sequencer #(
    .ADDR_WIDTH(AW), .MAX_LENGTH(ML), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .vector_length(vector_length), .widening(widening),
    .src2_base(src2_base), .src1_base(src1_base), .dst_base(dst_base),
`ifdef VFMA_SEQUENCER_MASK_EN
    .mask(mask),
`endif
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_vs2(rd_addr_vs2), .rd_addr_vs1(rd_addr_vs1),
    .rd_addr_vd(rd_addr_vd),
    .rd_data_vs2(rd_data_vs2), .rd_data_vs1(rd_data_vs1),
    .rd_data_vd(rd_data_vd),
    .fma_vs2(fma_vs2), .fma_vs1(fma_vs1), .fma_vdd(fma_vdd),
    .fma_vd(fma_vd), .fma_vd_high(fma_vd_high),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rf(input int bank, input logic [AW-1:0] a);
    return (64'(bank) << 56) | (64'(a) * 64'h0001_0003_0007);
  endfunction

  function automatic logic [63:0] f_lo(input logic [63:0] a, b, c);
    return a + b * 64'd3 + c;
  endfunction

  function automatic logic [63:0] f_hi(input logic [63:0] a, b, c);
    return a ^ {b[31:0], b[63:32]} ^ ~c;
  endfunction

  assign fma_vd      = f_lo(fma_vs2, fma_vs1, fma_vdd);
  assign fma_vd_high = f_hi(fma_vs2, fma_vs1, fma_vdd);

  // Register file: data appears one cycle after rd_en, garbage otherwise
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_vs2 <= rf(2, rd_addr_vs2);
      rd_data_vs1 <= rf(1, rd_addr_vs1);
      rd_data_vd  <= rf(3, rd_addr_vd);
    end else begin
      rd_data_vs2 <= 64'hBAD0_BAD0_BAD0_BAD0;
      rd_data_vs1 <= 64'hBAD1_BAD1_BAD1_BAD1;
      rd_data_vd  <= 64'hBAD3_BAD3_BAD3_BAD3;
    end
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [63:0]   d;
  } wr_t;

  wr_t wq[$];
  int  rd_cnt = 0;

  always @(posedge clk) begin
    if (wr_valid && wr_ready) wq.push_back('{wr_addr, wr_data});
    if (rd_en) rd_cnt <= rd_cnt + 1;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(input int len, input bit wide,
                       input logic [AW-1:0] s2, s1, d);
    @(negedge clk);
    vector_length = LW'(len);
    widening = wide;
    src2_base = s2;
    src1_base = s1;
    dst_base = d;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no done want done", name);
    end
  endtask

  task automatic wait_wr_valid(input string name);
    int t = 0;
    while (!wr_valid && t < 50) begin
      @(posedge clk);
      #1 t++;
    end
    chk({name, "_wr_valid"}, 64'(wr_valid), 64'd1);
  endtask

  typedef struct {
    int            len;
    bit            wide;
    logic [AW-1:0] s2;
    logic [AW-1:0] s1;
    logic [AW-1:0] d;
    int            lat;
  } vec_t;

  vec_t vt[6];

  initial begin
    int lat, wq0, rd0, eff;
    wr_t exp_w[$];
    string nm;

    vt[0] = '{3,  1'b0, 5'd0,  5'd8,  5'd16, 12};
    vt[1] = '{2,  1'b1, 5'd1,  5'd5,  5'd20, 10};
    vt[2] = '{0,  1'b0, 5'd3,  5'd4,  5'd5,  0};
    vt[3] = '{1,  1'b1, 5'd30, 5'd31, 5'd31, 5};
    vt[4] = '{40, 1'b0, 5'd2,  5'd9,  5'd7,  128};
    vt[5] = '{5,  1'b1, 5'd28, 5'd0,  5'd29, 25};

    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_fma_vs2", fma_vs2, 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      nm = $sformatf("v%0d", v);
      wq0 = wq.size();
      rd0 = rd_cnt;
      exp_w.delete();
      eff = (vt[v].len > ML) ? ML : vt[v].len;
      for (int i = 0; i < eff; i++) begin
        logic [AW-1:0] la, ha;
        logic [63:0] a, b, c;
        la = vt[v].wide ? AW'(vt[v].d + 2 * i) : AW'(vt[v].d + i);
        ha = AW'(vt[v].d + 2 * i + 1);
        a = rf(2, AW'(vt[v].s2 + i));
        b = rf(1, AW'(vt[v].s1 + i));
        c = rf(3, la);
        exp_w.push_back('{la, f_lo(a, b, c)});
        if (vt[v].wide) exp_w.push_back('{ha, f_hi(a, b, c)});
      end
      issue(vt[v].len, vt[v].wide, vt[v].s2, vt[v].s1, vt[v].d);
      wait_done(nm, lat);
      chk({nm, "_latency"}, 64'(lat), 64'(vt[v].lat));
      chk({nm, "_reads"}, 64'(rd_cnt - rd0), 64'(eff));
      chk({nm, "_nwrites"}, 64'(wq.size() - wq0), 64'(exp_w.size()));
      for (int k = 0; k < exp_w.size(); k++) begin
        if (wq0 + k < wq.size()) begin
          chk($sformatf("%s_w%0d_addr", nm, k), 64'(wq[wq0 + k].a),
              64'(exp_w[k].a));
          chk($sformatf("%s_w%0d_data", nm, k), wq[wq0 + k].d,
              exp_w[k].d);
        end
      end
      @(posedge clk);
      #1;
      chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
      chk({nm, "_idle_done"}, 64'(done), 64'd0);
    end

    // Write back-pressure with a start attempted while busy
    begin
      logic [63:0] ed;
      ed = f_lo(rf(2, 5'd4), rf(1, 5'd6), rf(3, 5'd10));
      wq0 = wq.size();
      rd0 = rd_cnt;
      wr_ready = 1'b0;
      issue(1, 1'b0, 5'd4, 5'd6, 5'd10);
      wait_wr_valid("stall");
      chk("stall_addr0", 64'(wr_addr), 64'd10);
      chk("stall_data0", wr_data, ed);
      start = 1'b1;
      vector_length = LW'(5);
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1 start = 1'b0;
        chk($sformatf("stall%0d_valid", c), 64'(wr_valid), 64'd1);
        chk($sformatf("stall%0d_addr", c), 64'(wr_addr), 64'd10);
        chk($sformatf("stall%0d_data", c), wr_data, ed);
        chk($sformatf("stall%0d_nowr", c), 64'(wq.size() - wq0), 64'd0);
      end
      wr_ready = 1'b1;
      wait_done("stall", lat);
      chk("stall_nwrites", 64'(wq.size() - wq0), 64'd1);
      start = 1'b1;
      vector_length = LW'(1);
      @(posedge clk);
      #1 start = 1'b0;
      chk("start_in_done_ignored", 64'(busy), 64'd0);
      chk("stall_reads", 64'(rd_cnt - rd0), 64'd1);
    end

    // Reset while the high half of a widening result is pending
    begin
      wq0 = wq.size();
      wr_ready = 1'b0;
      issue(1, 1'b1, 5'd0, 5'd0, 5'd12);
      wait_wr_valid("rsthi");
      wr_ready = 1'b1;
      @(posedge clk);
      #1 wr_ready = 1'b0;
      chk("rsthi_valid", 64'(wr_valid), 64'd1);
      chk("rsthi_addr", 64'(wr_addr), 64'd13);
      chk("rsthi_nwr", 64'(wq.size() - wq0), 64'd1);
      #1 reset = 1'b1;
      #1;
      chk("rsthi_valid_after", 64'(wr_valid), 64'd0);
      chk("rsthi_busy_after", 64'(busy), 64'd0);
      chk("rsthi_addr_after", 64'(wr_addr), 64'd0);
      chk("rsthi_data_after", wr_data, 64'd0);
      chk("rsthi_fma_after", fma_vs2, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      wr_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("rsthi_no_more_wr", 64'(wq.size() - wq0), 64'd1);
      chk("rsthi_idle", 64'(busy), 64'd0);
    end

`ifdef VFMA_SEQUENCER_MASK_EN
    // Masked elements are skipped in a single cycle with no accesses
    begin
      wq0 = wq.size();
      rd0 = rd_cnt;
      mask = 32'h5;
      issue(4, 1'b0, 5'd0, 5'd8, 5'd16);
      wait_done("mask", lat);
      chk("mask_latency", 64'(lat), 64'd10);
      chk("mask_reads", 64'(rd_cnt - rd0), 64'd2);
      chk("mask_nwrites", 64'(wq.size() - wq0), 64'd2);
      if (wq.size() - wq0 >= 2) begin
        chk("mask_w0_addr", 64'(wq[wq0].a), 64'd16);
        chk("mask_w0_data", wq[wq0].d,
            f_lo(rf(2, 5'd0), rf(1, 5'd8), rf(3, 5'd16)));
        chk("mask_w1_addr", 64'(wq[wq0 + 1].a), 64'd18);
        chk("mask_w1_data", wq[wq0 + 1].d,
            f_lo(rf(2, 5'd2), rf(1, 5'd10), rf(3, 5'd18)));
      end
      mask = '1;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
